// File: rtl/store_queue_if.sv
// Store queue port bundle: issue, AGU, CDB snoop, branch, load-query and
// data-memory write signals. The slave modport is the queue side.
interface store_queue_if #(
    parameter int N_ENTRY    = 8,
    parameter int ADDR_WIDTH = 17,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 6,
    parameter int B_WIDTH    = 3
);
    localparam int PW = $clog2(N_ENTRY);
    localparam int CW = PW + 1;

    logic                  issue_valid;
    logic                  issue_ready;
    logic                  issue_fpr;
    logic                  issue_addr_valid;
    logic [ADDR_WIDTH-1:0] issue_addr;
    logic                  issue_data_valid;
    logic [TAG_WIDTH-1:0]  issue_data_tag;
    logic [DATA_WIDTH-1:0] issue_data;
    logic [B_WIDTH-1:0]    issue_b_count;
    logic [PW-1:0]         issue_idx;

    logic                  agu_valid;
    logic [PW-1:0]         agu_idx;
    logic [ADDR_WIDTH-1:0] agu_addr;

    logic                  gpr_cdb_valid;
    logic [TAG_WIDTH-1:0]  gpr_cdb_tag;
    logic [DATA_WIDTH-1:0] gpr_cdb_data;
    logic                  fpr_cdb_valid;
    logic [TAG_WIDTH-1:0]  fpr_cdb_tag;
    logic [DATA_WIDTH-1:0] fpr_cdb_data;

    logic                  b_commit;
    logic                  failure;

    logic [CW-1:0]         ld_older;
    logic [ADDR_WIDTH-1:0] ld_addr;
    logic                  ld_ready;
    logic                  ld_hit;
    logic [DATA_WIDTH-1:0] ld_data;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_din;

    logic [CW-1:0]         sq_count;
    logic                  sq_empty;

    modport master (
        output issue_valid, issue_fpr, issue_addr_valid, issue_addr,
               issue_data_valid, issue_data_tag, issue_data, issue_b_count,
               agu_valid, agu_idx, agu_addr,
               gpr_cdb_valid, gpr_cdb_tag, gpr_cdb_data,
               fpr_cdb_valid, fpr_cdb_tag, fpr_cdb_data,
               b_commit, failure, ld_older, ld_addr,
        input  issue_ready, issue_idx, ld_ready, ld_hit, ld_data,
               mem_we, mem_addr, mem_din, sq_count, sq_empty
    );

    modport slave (
        input  issue_valid, issue_fpr, issue_addr_valid, issue_addr,
               issue_data_valid, issue_data_tag, issue_data, issue_b_count,
               agu_valid, agu_idx, agu_addr,
               gpr_cdb_valid, gpr_cdb_tag, gpr_cdb_data,
               fpr_cdb_valid, fpr_cdb_tag, fpr_cdb_data,
               b_commit, failure, ld_older, ld_addr,
        output issue_ready, issue_idx, ld_ready, ld_hit, ld_data,
               mem_we, mem_addr, mem_din, sq_count, sq_empty
    );
endinterface

// File: rtl/store_queue.sv
// Circular store queue: holds stores until address, data and branch state
// are resolved, commits in order, and serves load forwarding queries.
module store_queue #(
    parameter int N_ENTRY    = 8,
    parameter int ADDR_WIDTH = 17,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 6,
    parameter int B_WIDTH    = 3
) (
    input  logic         clk,
    input  logic         reset,
    store_queue_if.slave bus
);
    localparam int PW = $clog2(N_ENTRY);
    localparam int CW = PW + 1;

    logic [PW-1:0]         head_q, head_d;
    logic [PW-1:0]         tail_q, tail_d;
    logic [CW-1:0]         count_q, count_d;

    logic                  av_q   [N_ENTRY];
    logic                  av_d   [N_ENTRY];
    logic [ADDR_WIDTH-1:0] addr_q [N_ENTRY];
    logic [ADDR_WIDTH-1:0] addr_d [N_ENTRY];
    logic                  fpr_q  [N_ENTRY];
    logic                  fpr_d  [N_ENTRY];
    logic                  dv_q   [N_ENTRY];
    logic                  dv_d   [N_ENTRY];
    logic [TAG_WIDTH-1:0]  tag_q  [N_ENTRY];
    logic [TAG_WIDTH-1:0]  tag_d  [N_ENTRY];
    logic [DATA_WIDTH-1:0] data_q [N_ENTRY];
    logic [DATA_WIDTH-1:0] data_d [N_ENTRY];
    logic [B_WIDTH-1:0]    bc_q   [N_ENTRY];
    logic [B_WIDTH-1:0]    bc_d   [N_ENTRY];

    logic                  jc_valid_q;
    logic [ADDR_WIDTH-1:0] jc_addr_q;
    logic [DATA_WIDTH-1:0] jc_data_q;

    logic                  commit;
    logic                  accept;
    logic                  bc_dec;
    logic [CW-1:0]         survivors;
    logic                  occ        [N_ENTRY];
    logic [PW-1:0]         win_idx    [N_ENTRY];
    logic                  snoop_hit  [N_ENTRY];
    logic [DATA_WIDTH-1:0] snoop_data [N_ENTRY];
    logic                  iss_snoop;
    logic [DATA_WIDTH-1:0] iss_cdb_data;
    logic [B_WIDTH-1:0]    issue_bc;

    assign commit = (count_q != '0) && (bc_q[head_q] == '0) && av_q[head_q] && dv_q[head_q];
    assign bus.issue_ready = ((count_q < CW'(N_ENTRY)) || commit) && !bus.failure;
    assign accept = bus.issue_valid && bus.issue_ready;
    assign bc_dec = bus.b_commit && !bus.failure;

    assign bus.issue_idx = tail_q;
    assign bus.mem_we    = commit;
    assign bus.mem_addr  = addr_q[head_q];
    assign bus.mem_din   = data_q[head_q];
    assign bus.sq_count  = count_q;
    assign bus.sq_empty  = (count_q == '0);

    // Occupancy is derived from the distance to head, so entries never move.
    always_comb begin
        for (int unsigned i = 0; i < N_ENTRY; i++) begin
            win_idx[i] = head_q + PW'(i);
            occ[i]     = {1'b0, PW'(PW'(i) - head_q)} < count_q;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < N_ENTRY; i++) begin
            if (fpr_q[i]) begin
                snoop_hit[i]  = bus.fpr_cdb_valid && (bus.fpr_cdb_tag == tag_q[i]);
                snoop_data[i] = bus.fpr_cdb_data;
            end else begin
                snoop_hit[i]  = bus.gpr_cdb_valid && (bus.gpr_cdb_tag == tag_q[i]);
                snoop_data[i] = bus.gpr_cdb_data;
            end
        end
    end

    always_comb begin
        if (bus.issue_fpr) begin
            iss_snoop    = bus.fpr_cdb_valid && (bus.fpr_cdb_tag == bus.issue_data_tag);
            iss_cdb_data = bus.fpr_cdb_data;
        end else begin
            iss_snoop    = bus.gpr_cdb_valid && (bus.gpr_cdb_tag == bus.issue_data_tag);
            iss_cdb_data = bus.gpr_cdb_data;
        end
        // The issuing store counted a branch that resolves this same cycle.
        issue_bc = bus.issue_b_count;
        if (bc_dec && bus.issue_b_count != '0) issue_bc = bus.issue_b_count - B_WIDTH'(1);
    end

    always_comb begin
        survivors = '0;
        for (int unsigned i = 0; i < N_ENTRY; i++) begin
            if (occ[i] && bc_q[i] == '0) survivors = survivors + CW'(1);
        end
    end

    always_comb begin
        head_d = head_q + PW'(commit);
        if (bus.failure) begin
            tail_d  = head_q + survivors[PW-1:0];
            count_d = survivors - CW'(commit);
        end else begin
            tail_d  = tail_q + PW'(accept);
            count_d = count_q + CW'(accept) - CW'(commit);
        end

        av_d   = av_q;
        addr_d = addr_q;
        fpr_d  = fpr_q;
        dv_d   = dv_q;
        tag_d  = tag_q;
        data_d = data_q;
        bc_d   = bc_q;

        for (int unsigned i = 0; i < N_ENTRY; i++) begin
            if (accept && tail_q == PW'(i)) begin
                av_d[i]   = bus.issue_addr_valid;
                addr_d[i] = bus.issue_addr;
                fpr_d[i]  = bus.issue_fpr;
                tag_d[i]  = bus.issue_data_tag;
                bc_d[i]   = issue_bc;
                if (bus.issue_data_valid) begin
                    dv_d[i]   = 1'b1;
                    data_d[i] = bus.issue_data;
                end else if (iss_snoop) begin
                    dv_d[i]   = 1'b1;
                    data_d[i] = iss_cdb_data;
                end else begin
                    dv_d[i]   = 1'b0;
                    data_d[i] = bus.issue_data;
                end
            end else if (occ[i]) begin
                if (bus.agu_valid && bus.agu_idx == PW'(i)) begin
                    av_d[i]   = 1'b1;
                    addr_d[i] = bus.agu_addr;
                end
                if (!dv_q[i] && snoop_hit[i]) begin
                    dv_d[i]   = 1'b1;
                    data_d[i] = snoop_data[i];
                end
                if (bc_dec && bc_q[i] != '0) bc_d[i] = bc_q[i] - B_WIDTH'(1);
            end
        end
    end

    // Youngest matching window entry wins; the just-committed register covers
    // the store whose memory write lands in the same cycle as the load read.
    always_comb begin
        bus.ld_ready = 1'b1;
        bus.ld_hit   = 1'b0;
        bus.ld_data  = '0;
        for (int unsigned k = 0; k < N_ENTRY; k++) begin
            if (CW'(k) < bus.ld_older) begin
                if (!(av_q[win_idx[k]] && dv_q[win_idx[k]])) bus.ld_ready = 1'b0;
                if (av_q[win_idx[k]] && addr_q[win_idx[k]] == bus.ld_addr) begin
                    bus.ld_hit  = 1'b1;
                    bus.ld_data = data_q[win_idx[k]];
                end
            end
        end
        if (!bus.ld_hit && jc_valid_q && jc_addr_q == bus.ld_addr) begin
            bus.ld_hit  = 1'b1;
            bus.ld_data = jc_data_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            jc_valid_q <= 1'b0;
            jc_addr_q  <= '0;
            jc_data_q  <= '0;
            for (int unsigned i = 0; i < N_ENTRY; i++) begin
                av_q[i]   <= 1'b0;
                addr_q[i] <= '0;
                fpr_q[i]  <= 1'b0;
                dv_q[i]   <= 1'b0;
                tag_q[i]  <= '0;
                data_q[i] <= '0;
                bc_q[i]   <= '0;
            end
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            jc_valid_q <= commit;
            jc_addr_q  <= addr_q[head_q];
            jc_data_q  <= data_q[head_q];
            for (int unsigned i = 0; i < N_ENTRY; i++) begin
                av_q[i]   <= av_d[i];
                addr_q[i] <= addr_d[i];
                fpr_q[i]  <= fpr_d[i];
                dv_q[i]   <= dv_d[i];
                tag_q[i]  <= tag_d[i];
                data_q[i] <= data_d[i];
                bc_q[i]   <= bc_d[i];
            end
        end
    end
endmodule

// File: tb/tb_store_queue.sv
// Directed bench for store_queue with N_ENTRY=4: in-order commit, CDB wakeup,
// forwarding, AGU wait, squash on failure, just-committed forwarding, async reset.
module tb_store_queue;
    localparam int N  = 4;
    localparam int AW = 17;
    localparam int DW = 32;
    localparam int TW = 6;
    localparam int BW = 3;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    store_queue_if #(.N_ENTRY(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                     .TAG_WIDTH(TW), .B_WIDTH(BW)) sq_if ();

    store_queue #(.N_ENTRY(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                  .TAG_WIDTH(TW), .B_WIDTH(BW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sq_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic fpr, input logic av, input logic [AW-1:0] a,
                         input logic dv, input logic [TW-1:0] tg,
                         input logic [DW-1:0] d, input logic [BW-1:0] bc);
        sq_if.issue_valid      = 1'b1;
        sq_if.issue_fpr        = fpr;
        sq_if.issue_addr_valid = av;
        sq_if.issue_addr       = a;
        sq_if.issue_data_valid = dv;
        sq_if.issue_data_tag   = tg;
        sq_if.issue_data       = d;
        sq_if.issue_b_count    = bc;
    endtask

    task automatic no_issue;
        sq_if.issue_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        sq_if.issue_valid = 0; sq_if.issue_fpr = 0; sq_if.issue_addr_valid = 0;
        sq_if.issue_addr = '0; sq_if.issue_data_valid = 0; sq_if.issue_data_tag = '0;
        sq_if.issue_data = '0; sq_if.issue_b_count = '0;
        sq_if.agu_valid = 0; sq_if.agu_idx = '0; sq_if.agu_addr = '0;
        sq_if.gpr_cdb_valid = 0; sq_if.gpr_cdb_tag = '0; sq_if.gpr_cdb_data = '0;
        sq_if.fpr_cdb_valid = 0; sq_if.fpr_cdb_tag = '0; sq_if.fpr_cdb_data = '0;
        sq_if.b_commit = 0; sq_if.failure = 0; sq_if.ld_older = '0; sq_if.ld_addr = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("rst_count", sq_if.sq_count, 0);
        chk("rst_empty", sq_if.sq_empty, 1);
        chk("rst_we", sq_if.mem_we, 0);
        chk("rst_hit", sq_if.ld_hit, 0);
        chk("rst_ready", sq_if.issue_ready, 1);

        // Four immediate-address stores commit back to back, one cycle behind issue.
        issue(0, 1, 10, 1, 0, 32'h100, 0);
        #1 chk("t1_idx0", sq_if.issue_idx, 0);
        chk("t1_we_idle", sq_if.mem_we, 0);
        tick;
        for (int k = 1; k < 4; k++) begin
            issue(0, 1, AW'(10 + k), 1, 0, DW'(32'h100 + k), 0);
            #1;
            chk("t1_we", sq_if.mem_we, 1);
            chk("t1_addr", sq_if.mem_addr, 10 + k - 1);
            chk("t1_din", sq_if.mem_din, 32'h100 + k - 1);
            chk("t1_idx", sq_if.issue_idx, k);
            chk("t1_count", sq_if.sq_count, 1);
            tick;
        end
        no_issue;
        #1 chk("t1_we_last", sq_if.mem_we, 1);
        chk("t1_addr_last", sq_if.mem_addr, 13);
        chk("t1_din_last", sq_if.mem_din, 32'h103);
        tick;
        #1 chk("t1_empty", sq_if.sq_empty, 1);
        chk("t1_we_done", sq_if.mem_we, 0);

        // Fill with data pending on tag 5, wake all with one CDB broadcast.
        for (int k = 0; k < 4; k++) begin
            issue(0, 1, AW'(20 + k), 0, 5, 0, 0);
            #1 chk("t2_ready_fill", sq_if.issue_ready, 1);
            tick;
        end
        no_issue;
        #1 chk("t2_full_ready", sq_if.issue_ready, 0);
        chk("t2_full_count", sq_if.sq_count, 4);
        chk("t2_full_we", sq_if.mem_we, 0);
        sq_if.gpr_cdb_valid = 1; sq_if.gpr_cdb_tag = 5; sq_if.gpr_cdb_data = 32'hDEAD;
        tick;
        sq_if.gpr_cdb_valid = 0;
        issue(0, 1, 30, 1, 0, 32'h77, 0);
        #1 chk("t2_full_commit_ready", sq_if.issue_ready, 1);
        chk("t2_wrap_idx", sq_if.issue_idx, 0);
        chk("t2_we0", sq_if.mem_we, 1);
        chk("t2_addr0", sq_if.mem_addr, 20);
        chk("t2_din0", sq_if.mem_din, 32'hDEAD);
        tick;
        no_issue;
        for (int k = 1; k < 4; k++) begin
            #1;
            chk("t2_we", sq_if.mem_we, 1);
            chk("t2_addr", sq_if.mem_addr, 20 + k);
            chk("t2_din", sq_if.mem_din, 32'hDEAD);
            chk("t2_count", sq_if.sq_count, 5 - k);
            tick;
        end
        #1 chk("t2_addr5", sq_if.mem_addr, 30);
        chk("t2_din5", sq_if.mem_din, 32'h77);
        tick;
        #1 chk("t2_empty", sq_if.sq_empty, 1);

        // Two stores to address 7 held by a pending branch; query forwarding.
        issue(0, 1, 7, 1, 0, 1, 1);
        #1 chk("t3_idx", sq_if.issue_idx, 1);
        tick;
        issue(0, 1, 7, 1, 0, 2, 1);
        tick;
        no_issue;
        sq_if.ld_addr = 7; sq_if.ld_older = 2;
        #1 chk("t3_ready2", sq_if.ld_ready, 1);
        chk("t3_hit2", sq_if.ld_hit, 1);
        chk("t3_data2", sq_if.ld_data, 2);
        chk("t3_held_we", sq_if.mem_we, 0);
        sq_if.ld_older = 1;
        #1 chk("t3_hit1", sq_if.ld_hit, 1);
        chk("t3_data1", sq_if.ld_data, 1);
        sq_if.ld_addr = 8; sq_if.ld_older = 2;
        #1 chk("t3_miss", sq_if.ld_hit, 0);
        sq_if.ld_older = 0; sq_if.b_commit = 1;
        tick;
        sq_if.b_commit = 0;
        #1 chk("t3_c1_we", sq_if.mem_we, 1);
        chk("t3_c1_din", sq_if.mem_din, 1);
        tick;
        #1 chk("t3_c2_din", sq_if.mem_din, 2);
        tick;
        #1 chk("t3_empty", sq_if.sq_empty, 1);

        // Address pending until AGU writes it.
        issue(0, 0, 0, 1, 0, 32'h44, 0);
        #1 chk("t4_idx", sq_if.issue_idx, 3);
        tick;
        no_issue;
        sq_if.ld_older = 1; sq_if.ld_addr = 50;
        #1 chk("t4_not_ready", sq_if.ld_ready, 0);
        chk("t4_no_commit", sq_if.mem_we, 0);
        chk("t4_no_hit", sq_if.ld_hit, 0);
        sq_if.agu_valid = 1; sq_if.agu_idx = 3; sq_if.agu_addr = 50;
        tick;
        sq_if.agu_valid = 0;
        #1 chk("t4_ready", sq_if.ld_ready, 1);
        chk("t4_hit", sq_if.ld_hit, 1);
        chk("t4_data", sq_if.ld_data, 32'h44);
        chk("t4_we", sq_if.mem_we, 1);
        chk("t4_addr", sq_if.mem_addr, 50);
        sq_if.ld_older = 0;
        tick;

        // Squash: b_counts 0,0,1,2 with head data pending.
        issue(0, 1, 60, 0, 9, 0, 0);      tick;
        issue(0, 1, 61, 1, 0, 32'h61, 0); tick;
        issue(0, 1, 62, 1, 0, 32'h62, 1); tick;
        issue(0, 1, 63, 1, 0, 32'h63, 2); tick;
        no_issue;
        sq_if.failure = 1;
        #1 chk("t5_fail_ready", sq_if.issue_ready, 0);
        chk("t5_fail_we", sq_if.mem_we, 0);
        tick;
        sq_if.failure = 0;
        #1 chk("t5_count", sq_if.sq_count, 2);
        chk("t5_tail", sq_if.issue_idx, 2);
        issue(0, 1, 70, 1, 0, 32'h70, 0);
        #1 chk("t5_reissue_ready", sq_if.issue_ready, 1);
        tick;
        no_issue;
        #1 chk("t5_count3", sq_if.sq_count, 3);
        sq_if.gpr_cdb_valid = 1; sq_if.gpr_cdb_tag = 9; sq_if.gpr_cdb_data = 32'h99;
        tick;
        sq_if.gpr_cdb_valid = 0;
        #1 chk("t5_c0_addr", sq_if.mem_addr, 60);
        chk("t5_c0_din", sq_if.mem_din, 32'h99);
        chk("t5_c0_we", sq_if.mem_we, 1);
        tick;
        #1 chk("t5_c1_addr", sq_if.mem_addr, 61);
        chk("t5_c1_din", sq_if.mem_din, 32'h61);
        tick;
        #1 chk("t5_c2_addr", sq_if.mem_addr, 70);
        chk("t5_c2_din", sq_if.mem_din, 32'h70);
        tick;
        #1 chk("t5_empty", sq_if.sq_empty, 1);

        // Just-committed forwarding, then asynchronous reset mid-stream.
        issue(0, 1, 3, 1, 0, 9, 0);
        tick;
        no_issue;
        #1 chk("t6_we", sq_if.mem_we, 1);
        chk("t6_addr", sq_if.mem_addr, 3);
        tick;
        sq_if.ld_addr = 3; sq_if.ld_older = 0;
        #1 chk("t6_jc_hit", sq_if.ld_hit, 1);
        chk("t6_jc_data", sq_if.ld_data, 9);
        chk("t6_jc_ready", sq_if.ld_ready, 1);
        sq_if.ld_addr = 4;
        #1 chk("t6_jc_miss", sq_if.ld_hit, 0);
        issue(0, 1, 80, 1, 0, 32'h80, 0);
        tick;
        issue(0, 1, 81, 1, 0, 32'h81, 1);
        #1 chk("t6_pre_rst_we", sq_if.mem_we, 1);
        reset = 1'b1;
        no_issue;
        #1 chk("t6_rst_empty", sq_if.sq_empty, 1);
        chk("t6_rst_we", sq_if.mem_we, 0);
        chk("t6_rst_count", sq_if.sq_count, 0);
        tick;
        tick;
        reset = 1'b0;
        sq_if.ld_addr = 80;
        #1 chk("t6_post_hit", sq_if.ld_hit, 0);
        chk("t6_post_ready", sq_if.issue_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
